// File: rtl/bsg_vanilla_rload_wb_queue.sv
// Remote load writeback queue: buffers remote load responses in arrival order
// and presents the oldest one, formatted, to either the integer or the FP
// register file writeback port.

package bsg_vanilla_rload_wb_queue_pkg;

    localparam int bsg_manycore_reg_id_width_gp = 5;
    localparam int rload_data_width_gp          = 32;

    typedef struct packed {
        logic                                    float_wb;
        logic [bsg_manycore_reg_id_width_gp-1:0] reg_id;
        logic                                    is_unsigned_op;
        logic                                    is_byte_op;
        logic                                    is_hex_op;
        logic [1:0]                              part_sel;
        logic [rload_data_width_gp-1:0]          data;
    } remote_load_resp_s;

endpackage

module bsg_vanilla_rload_wb_queue
    import bsg_vanilla_rload_wb_queue_pkg::*;
#(
    parameter int els_p          = 4,
    parameter int reg_id_width_p = bsg_manycore_reg_id_width_gp,
    parameter int data_width_p   = rload_data_width_gp
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       v_i,
    input  remote_load_resp_s          resp_i,
    output logic                       ready_o,

    output logic                       int_wb_v_o,
    input  logic                       int_wb_yumi_i,
    output logic                       float_wb_v_o,
    input  logic                       float_wb_yumi_i,

    output logic [reg_id_width_p-1:0]  wb_reg_id_o,
    output logic [data_width_p-1:0]    wb_data_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w_lp   = $clog2(els_p);
    localparam int count_w_lp = $clog2(els_p+1);

    typedef logic [ptr_w_lp-1:0]   ptr_t;
    typedef logic [count_w_lp-1:0] count_t;

    remote_load_resp_s mem [els_p];
    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    count_t            count_r;
    logic              ready_r;

    remote_load_resp_s head;
    logic              not_empty;
    logic              enq;
    logic              deq;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(els_p-1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign head      = mem[rd_ptr];
    assign not_empty = (count_r != '0);

    // ready_r holds ready_o low during reset and for the edge on which reset is released
    assign ready_o      = ready_r & (count_r != count_t'(els_p));
    assign int_wb_v_o   = not_empty & ~head.float_wb;
    assign float_wb_v_o = not_empty &  head.float_wb;

    assign enq = v_i & ready_o;
    assign deq = (int_wb_yumi_i & int_wb_v_o) | (float_wb_yumi_i & float_wb_v_o);

    assign wb_reg_id_o = head.reg_id;
    assign count_o     = count_r;

    // Queue state: pointers, occupancy and entry storage
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            ready_r <= 1'b0;
            // NOTE: storage is reset so the head outputs never show X from an unwritten entry
            for (int i = 0; i < els_p; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values
            ready_r <= 1'b1;
            if (enq) begin
                mem[wr_ptr] <= resp_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (enq && !deq) begin
                count_r <= count_r + count_t'(1);
            end else if (!enq && deq) begin
                count_r <= count_r - count_t'(1);
            end
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] hex_sel;

    // Format the head entry: sub-word select and extension for integer loads only
    always_comb begin
        // NOTE: every comb output gets a default first so no latch can be inferred
        byte_sel  = 8'(head.data >> {head.part_sel, 3'b000});
        hex_sel   = 16'(head.data >> {head.part_sel[1], 4'b0000});
        wb_data_o = head.data;
        if (!head.float_wb) begin
            if (head.is_byte_op) begin
                wb_data_o = head.is_unsigned_op
                          ? {{(data_width_p-8){1'b0}}, byte_sel}
                          : {{(data_width_p-8){byte_sel[7]}}, byte_sel};
            end else if (head.is_hex_op) begin
                wb_data_o = head.is_unsigned_op
                          ? {{(data_width_p-16){1'b0}}, hex_sel}
                          : {{(data_width_p-16){hex_sel[15]}}, hex_sel};
            end
        end
    end

    // A grant without its matching valid is a protocol error from the consumer
    a_int_yumi_has_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(int_wb_yumi_i && !int_wb_v_o));
    a_float_yumi_has_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(float_wb_yumi_i && !float_wb_v_o));

endmodule
